// File: rtl/spmm_out_buffer_pkg.sv
// Shared types and sizing for the SpMM output buffer: element type, tile geometry, FSM states.
package spmm_out_buffer_pkg;

  localparam int unsigned N           = 16;
  localparam int unsigned W           = 8;
  localparam int unsigned LGN         = $clog2(N);
  localparam int unsigned DRAIN_BEATS = N / 4;
  localparam int unsigned BeatW       = (DRAIN_BEATS > 1) ? $clog2(DRAIN_BEATS) : 1;

  typedef struct packed {
    logic [W-1:0] data;
  } data_t;

  // One tile column (indexed by row) and one 4-row drain beat ([row-in-beat][column]).
  typedef data_t [N-1:0]      col_t;
  typedef data_t [3:0][N-1:0] beat_t;

  typedef enum logic [1:0] {
    StFill,
    StFull,
    StDrain
  } state_e;

endpackage

// File: rtl/spmm_out_buffer_if.sv
// Write-side and drain-side handshake bundle of the SpMM output buffer.
interface spmm_out_buffer_if;
  import spmm_out_buffer_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [LGN-1:0] in_col;
  logic           in_os;
  col_t           in_data;
  logic           out_ready;
  logic           out_start;
  logic           out_valid;
  beat_t          out_data;

  // master: the PE array / drain consumer side; slave: the buffer itself.
  modport master (
    output in_valid, in_col, in_os, in_data, out_start,
    input  in_ready, out_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_col, in_os, in_data, out_start,
    output in_ready, out_ready, out_valid, out_data
  );

endinterface

// File: rtl/spmm_out_buffer_out_acc_col.sv
// One tile column of N cells: overwrite or accumulate on write.
// OUT_BUF_SAT_EN selects saturating accumulation; default wraps modulo 2^W.
module spmm_out_buffer_out_acc_col
  import spmm_out_buffer_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic wr_en,
  input  logic os,
  input  col_t wr_data,
  output col_t col
);

  col_t col_q, col_d;

  function automatic logic [W-1:0] acc(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef OUT_BUF_SAT_EN
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
    return a + b;
`endif
  endfunction

  always_comb begin
    col_d = col_q;
    if (wr_en) begin
      for (int r = 0; r < N; r++) begin
        col_d[r].data = os ? acc(col_q[r].data, wr_data[r].data) : wr_data[r].data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

  assign col = col_q;

endmodule

// File: rtl/spmm_out_buffer.sv
// SpMM output buffer: collects N result columns, then drains the tile as N/4 row-ordered beats.
// Build option OUT_BUF_SAT_EN (see out_acc_col) makes in_os accumulation saturate.
module spmm_out_buffer
  import spmm_out_buffer_pkg::*;
(
  input logic               clock,
  input logic               reset,
  spmm_out_buffer_if.slave  bus
);

  state_e           state_q;
  logic [N-1:0]     written_q;
  logic [BeatW-1:0] beat_q;
  logic             in_ready_q;
  logic             out_ready_q;
  logic             out_valid_q;
  beat_t            out_data_q;

  col_t             cols [N];
  logic             wr_fire;
  logic [N-1:0]     wr_sel;
  logic [N-1:0]     written_next;
  logic [BeatW-1:0] beat_sel;
  beat_t            drain_rows;

  assign wr_fire = bus.in_valid && in_ready_q;

  always_comb begin
    wr_sel = '0;
    wr_sel[bus.in_col] = wr_fire;
  end

  assign written_next = written_q | wr_sel;

  for (genvar gc = 0; gc < N; gc++) begin : g_col
    spmm_out_buffer_out_acc_col u_col (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_sel[gc]),
      .os      (bus.in_os),
      .wr_data (bus.in_data),
      .col     (cols[gc])
    );
  end

  // Beat to be registered at the next edge: 0 when launching, current+1 while draining.
  assign beat_sel = (state_q == StDrain) ? beat_q + BeatW'(1) : '0;

  always_comb begin
    drain_rows = '0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < N; c++) begin
        drain_rows[k][c] = cols[c][LGN'({beat_sel, 2'b00}) + LGN'(k)];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StFill;
      written_q   <= '0;
      beat_q      <= '0;
      in_ready_q  <= 1'b1;
      out_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        StFill: begin
          if (wr_fire) begin
            written_q <= written_next;
            if (&written_next) begin
              state_q     <= StFull;
              in_ready_q  <= 1'b0;
              out_ready_q <= 1'b1;
            end
          end
        end
        StFull: begin
          if (bus.out_start) begin
            state_q     <= StDrain;
            out_ready_q <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= drain_rows;
            beat_q      <= '0;
          end
        end
        StDrain: begin
          // Tile contents are kept; only the bitmap is cleared for the next fill.
          if (beat_q == BeatW'(DRAIN_BEATS - 1)) begin
            state_q     <= StFill;
            written_q   <= '0;
            beat_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
          end else begin
            beat_q     <= beat_sel;
            out_data_q <= drain_rows;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_ready = out_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
